// File: rtl/lsu_ctrl.sv
// Load/store unit: aligns RV64 loads/stores onto a doubleword memory port,
// runs one valid/ready bus transaction and formats the result for writeback.
module lsu_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic             wen_q;
  logic [2:0]       f3_q;
  logic [2:0]       off_q;
  logic [CNT_W-1:0] cnt;

  logic        misal, illegal, tmo;
  logic [7:0]  mask_base, mask_in;
  logic [63:0] rd_sh, ld_ext;

  always_comb begin
    misal     = 1'b0;
    mask_base = 8'h01;
    case (req_func3[1:0])
      2'd0: begin misal = 1'b0;              mask_base = 8'h01; end
      2'd1: begin misal = req_addr[0];       mask_base = 8'h03; end
      2'd2: begin misal = |req_addr[1:0];    mask_base = 8'h0F; end
      default: begin misal = |req_addr[2:0]; mask_base = 8'hFF; end
    endcase
    mask_in = mask_base << req_addr[2:0];
    illegal = req_wen ? req_func3[2] : (req_func3 == 3'b111);
  end

  // Load data is extracted from the lane the original byte address selected.
  always_comb begin
    rd_sh  = mem_rdata >> {off_q, 3'b000};
    ld_ext = 64'd0;
    case (f3_q[1:0])
      2'd0: ld_ext = f3_q[2] ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
      2'd1: ld_ext = f3_q[2] ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
      2'd2: ld_ext = f3_q[2] ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      mem_valid  <= 1'b0;
      mem_addr   <= 64'd0;
      mem_wen    <= 1'b0;
      mem_wmask  <= 8'd0;
      mem_wdata  <= 64'd0;
      resp_valid <= 1'b0;
      resp_data  <= 64'd0;
      resp_err   <= 1'b0;
      wen_q      <= 1'b0;
      f3_q       <= 3'd0;
      off_q      <= 3'd0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          wen_q     <= req_wen;
          f3_q      <= req_func3;
          off_q     <= req_addr[2:0];
          req_ready <= 1'b0;
          mem_addr  <= {req_addr[63:3], 3'b000};
          mem_wdata <= req_wdata << {req_addr[2:0], 3'b000};
          if (misal || illegal) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= 64'd0;
          end else begin
            state     <= S_BUS;
            mem_valid <= 1'b1;
            mem_wen   <= req_wen;
            mem_wmask <= req_wen ? mask_in : 8'd0;
            cnt       <= '0;
          end
        end
        S_BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wen   <= 1'b0;
            mem_wmask <= 8'd0;
            if (wen_q) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= 64'd0;
            end else if (mem_rvalid) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_data  <= ld_ext;
            end else begin
              state <= S_WAIT;
              cnt   <= cnt + 1'b1;
            end
          end else if (tmo) begin
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_wmask  <= 8'd0;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= 64'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= ld_ext;
          end else if (tmo) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= 64'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: if (resp_ready) begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= 64'd0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// transactions scored against an arithmetic model of the load/store rules.
module tb_lsu_ctrl;

  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_func3;
  logic [63:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  typedef struct packed {
    logic        seen;
    logic        stable;
    logic        hold_ok;
    logic        idle_ok;
    logic        timed_out;
    logic [63:0] maddr;
    logic [63:0] mwd;
    logic [7:0]  mmask;
    logic        mwen;
    logic [63:0] rdata;
    logic        rerr;
    int          bus_n;
    int          lat;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: size in bytes, byte offset, plain shifts and masks.
  function automatic void model(input logic wen, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wd,
                                input logic [63:0] rd, output logic err,
                                output logic [7:0] mask, output logic [63:0] mwd,
                                output logic [63:0] rres);
    int unsigned nb  = 1 << f3[1:0];
    int unsigned off = addr[2:0];
    logic [127:0] lm, v;
    err  = (wen && f3[2]) || (!wen && f3 == 3'b111) || ((off % nb) != 0);
    mask = wen ? 8'((((1 << nb) - 1) << off) & 255) : 8'h00;
    mwd  = wd << (8 * off);
    lm   = (128'd1 << (8 * nb)) - 128'd1;
    v    = (128'(rd) >> (8 * off)) & lm;
    if (!f3[2] && v[8*nb-1]) v = v | ~lm;
    rres = (wen || err) ? 64'd0 : v[63:0];
  endfunction

  // Drives one request and a memory with the given ready/rvalid delays; records what it saw.
  task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rd,
                         input int rdy_dly, input int rv_dly, input int resp_dly,
                         output obs_t o);
    int bus_n = 0;
    int wait_n = 0;
    bit hs = 0;
    o = '0;
    o.stable = 1; o.hold_ok = 1; o.idle_ok = 1;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    if (!req_ready) begin o.timed_out = 1; return; end
    req_valid = 1; req_wen = wen; req_func3 = f3; req_addr = addr; req_wdata = wd;
    mem_rdata = rd;
    step();
    req_valid = 0;
    req_wen = 1'($urandom); req_func3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    o.lat = 1;
    for (int c = 0; c < 100 && !resp_valid; c++) begin
      if (req_ready) o.hold_ok = 0;
      if (mem_valid) begin
        if (!o.seen) begin
          o.seen = 1; o.maddr = mem_addr; o.mwd = mem_wdata; o.mmask = mem_wmask; o.mwen = mem_wen;
        end else if ({mem_addr, mem_wdata, mem_wmask, mem_wen} !== {o.maddr, o.mwd, o.mmask, o.mwen})
          o.stable = 0;
        mem_ready  = (bus_n >= rdy_dly);
        mem_rvalid = mem_ready && !wen && (rv_dly == 0);
        if (mem_ready) begin hs = 1; wait_n = 0; end
        bus_n++;
      end else begin
        mem_ready  = 0;
        mem_rvalid = hs && !wen && (wait_n + 1 == rv_dly);
        if (hs) wait_n++;
      end
      step();
      o.lat++;
    end
    mem_ready = 0; mem_rvalid = 0;
    o.bus_n = bus_n;
    if (!resp_valid) begin o.timed_out = 1; return; end
    o.rdata = resp_data; o.rerr = resp_err;
    if (req_ready || mem_valid) o.hold_ok = 0;
    mem_rdata = {$urandom, $urandom};
    for (int i = 0; i < resp_dly; i++) begin
      step();
      if (!resp_valid || resp_data !== o.rdata || resp_err !== o.rerr || req_ready || mem_valid)
        o.hold_ok = 0;
    end
    resp_ready = 1;
    step();
    resp_ready = 0;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) o.idle_ok = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) step();
    n_tests++; if ({mem_valid, mem_wen, resp_valid, resp_err} !== 4'b0) begin n_fail++;
      $display("FAIL rst_ctrl: got %b want 0000", {mem_valid, mem_wen, resp_valid, resp_err}); end
    n_tests++; if ({mem_addr, mem_wmask, mem_wdata, resp_data} !== '0) begin n_fail++;
      $display("FAIL rst_data: got %h %h %h %h want all 0", mem_addr, mem_wmask, mem_wdata, resp_data); end
    rst_n = 1;
    step();
    n_tests++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_store_sw();
    obs_t o;
    run_txn(1'b1, 3'b010, 64'h8000_0004, 64'h1122_3344_AABB_CCDD, 64'd0, 0, 0, 0, o);
    n_tests++; if (o.seen !== 1'b1 || o.bus_n != 1) begin n_fail++;
      $display("FAIL sw_beat: got seen=%b beats=%0d want 1/1", o.seen, o.bus_n); end
    n_tests++; if (o.maddr !== 64'h8000_0000 || o.mmask !== 8'hF0 || o.mwen !== 1'b1) begin n_fail++;
      $display("FAIL sw_bus: got %h %h %b want 80000000 f0 1", o.maddr, o.mmask, o.mwen); end
    n_tests++; if (o.mwd !== 64'hAABB_CCDD_0000_0000) begin n_fail++;
      $display("FAIL sw_wdata: got %h want aabbccdd00000000", o.mwd); end
    n_tests++; if (o.rdata !== 64'd0 || o.rerr !== 1'b0 || o.timed_out) begin n_fail++;
      $display("FAIL sw_resp: got %h err=%b to=%b want 0/0/0", o.rdata, o.rerr, o.timed_out); end
    n_tests++; if (o.lat != 2) begin n_fail++;
      $display("FAIL sw_lat: got %0d want 2", o.lat); end
  endtask

  task automatic test_load_lb();
    obs_t o;
    run_txn(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 0, o);
    n_tests++; if (o.rdata !== 64'hFFFF_FFFF_FFFF_FF80 || o.rerr !== 1'b0) begin n_fail++;
      $display("FAIL lb: got %h err=%b want ffffffffffffff80", o.rdata, o.rerr); end
    n_tests++; if (o.mmask !== 8'h00 || o.mwen !== 1'b0 || o.lat != 2) begin n_fail++;
      $display("FAIL lb_bus: got mask=%h wen=%b lat=%0d want 00/0/2", o.mmask, o.mwen, o.lat); end
    run_txn(1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 1, 0, o);
    n_tests++; if (o.rdata !== 64'h0000_0000_0000_0080 || o.rerr !== 1'b0) begin n_fail++;
      $display("FAIL lbu: got %h err=%b want 80", o.rdata, o.rerr); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, o);
    n_tests++; if (o.seen !== 1'b0 || o.lat != 1 || o.rerr !== 1'b1 || o.rdata !== 64'd0) begin n_fail++;
      $display("FAIL lw_mis: got seen=%b lat=%0d err=%b data=%h want 0/1/1/0", o.seen, o.lat, o.rerr, o.rdata); end
    run_txn(1'b1, 3'b011, 64'h8000_0001, 64'h1234, 64'd0, 0, 0, 0, o);
    n_tests++; if (o.seen !== 1'b0 || o.lat != 1 || o.rerr !== 1'b1 || o.rdata !== 64'd0) begin n_fail++;
      $display("FAIL sd_mis: got seen=%b lat=%0d err=%b data=%h want 0/1/1/0", o.seen, o.lat, o.rerr, o.rdata); end
    run_txn(1'b1, 3'b100, 64'h8000_0000, 64'h1234, 64'd0, 0, 0, 0, o);
    n_tests++; if (o.seen !== 1'b0 || o.rerr !== 1'b1) begin n_fail++;
      $display("FAIL st_illegal: got seen=%b err=%b want 0/1", o.seen, o.rerr); end
    run_txn(1'b0, 3'b111, 64'h8000_0000, 64'd0, 64'd5, 0, 0, 0, o);
    n_tests++; if (o.seen !== 1'b0 || o.rerr !== 1'b1) begin n_fail++;
      $display("FAIL ldu_illegal: got seen=%b err=%b want 0/1", o.seen, o.rerr); end
  endtask

  task automatic test_stall();
    obs_t o;
    logic e; logic [7:0] m; logic [63:0] w, r;
    logic [63:0] rd = 64'hDEAD_BEEF_8765_4321;
    model(1'b0, 3'b001, 64'h8000_0006, 64'd0, rd, e, m, w, r);
    run_txn(1'b0, 3'b001, 64'h8000_0006, 64'd0, rd, 5, 3, 4, o);
    n_tests++; if (o.stable !== 1'b1 || o.bus_n != 6) begin n_fail++;
      $display("FAIL stall_bus: got stable=%b beats=%0d want 1/6", o.stable, o.bus_n); end
    n_tests++; if (o.rdata !== r || o.rerr !== 1'b0) begin n_fail++;
      $display("FAIL stall_data: got %h err=%b want %h/0", o.rdata, o.rerr, r); end
    n_tests++; if (o.hold_ok !== 1'b1 || o.idle_ok !== 1'b1) begin n_fail++;
      $display("FAIL stall_hold: got hold=%b idle=%b want 1/1", o.hold_ok, o.idle_ok); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'h55, 1000, 0, 0, o);
    n_tests++; if (o.bus_n != TO || o.lat != TO + 1) begin n_fail++;
      $display("FAIL to_bus: got beats=%0d lat=%0d want %0d/%0d", o.bus_n, o.lat, TO, TO + 1); end
    n_tests++; if (o.rerr !== 1'b1 || o.rdata !== 64'd0 || o.timed_out) begin n_fail++;
      $display("FAIL to_bus_resp: got err=%b data=%h want 1/0", o.rerr, o.rdata); end
    run_txn(1'b0, 3'b011, 64'h8000_0010, 64'd0, 64'h55, 0, 1000, 0, o);
    n_tests++; if (o.bus_n != 1 || o.lat != TO + 1 || o.rerr !== 1'b1 || o.rdata !== 64'd0) begin n_fail++;
      $display("FAIL to_wait: got beats=%0d lat=%0d err=%b data=%h want 1/%0d/1/0", o.bus_n, o.lat, o.rerr, o.rdata, TO + 1); end
  endtask

  task automatic test_random();
    obs_t o;
    logic wen; logic [2:0] f3; logic [63:0] addr, wd, rd;
    logic e; logic [7:0] m; logic [63:0] w, r;
    for (int k = 0; k < 200; k++) begin
      wen = 1'($urandom); f3 = 3'($urandom);
      addr = {$urandom, $urandom}; wd = {$urandom, $urandom}; rd = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) addr[2:0] = 3'd0;
      model(wen, f3, addr, wd, rd, e, m, w, r);
      run_txn(wen, f3, addr, wd, rd, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(2, 0), o);
      n_tests++; if (o.timed_out || o.rerr !== e || o.rdata !== r) begin n_fail++;
        $display("FAIL rnd_resp[%0d]: got err=%b data=%h to=%b want %b/%h (wen=%b f3=%0d a=%h)",
                 k, o.rerr, o.rdata, o.timed_out, e, r, wen, f3, addr); end
      n_tests++; if (o.seen !== !e) begin n_fail++;
        $display("FAIL rnd_seen[%0d]: got %b want %b", k, o.seen, !e); end
      if (o.seen) begin
        n_tests++; if (o.maddr !== {addr[63:3], 3'b000} || o.mmask !== m || o.mwd !== w || o.mwen !== wen) begin n_fail++;
          $display("FAIL rnd_bus[%0d]: got %h %h %h %b want %h %h %h %b", k, o.maddr, o.mmask, o.mwd, o.mwen,
                   {addr[63:3], 3'b000}, m, w, wen); end
      end
      n_tests++; if (o.stable !== 1'b1 || o.hold_ok !== 1'b1 || o.idle_ok !== 1'b1) begin n_fail++;
        $display("FAIL rnd_hs[%0d]: got stable=%b hold=%b idle=%b want 1/1/1", k, o.stable, o.hold_ok, o.idle_ok); end
    end
  endtask

  task automatic test_reset_mid();
    // Reset while BUS: mem_valid must drop without a clock edge.
    req_valid = 1; req_wen = 0; req_func3 = 3'b011; req_addr = 64'h1000;
    step();
    req_valid = 0;
    n_tests++; if (mem_valid !== 1'b1) begin n_fail++;
      $display("FAIL rmid_bus: got mem_valid=%b want 1", mem_valid); end
    #2 rst_n = 0;
    #1;
    n_tests++; if ({mem_valid, mem_wen, mem_wmask, mem_addr, resp_valid} !== '0) begin n_fail++;
      $display("FAIL rmid_bus_rst: got valid=%b addr=%h resp=%b want 0", mem_valid, mem_addr, resp_valid); end
    step(); rst_n = 1; step();
    // Reset while WAIT, then a stray rvalid.
    req_valid = 1; req_wen = 0; req_func3 = 3'b011; req_addr = 64'h2000;
    step();
    req_valid = 0; mem_ready = 1;
    step();
    mem_ready = 0;
    #2 rst_n = 0;
    #1;
    n_tests++; if ({mem_valid, mem_wen, mem_wmask, mem_addr, mem_wdata, resp_valid, resp_err, resp_data} !== '0) begin n_fail++;
      $display("FAIL rmid_wait_rst: got valid=%b addr=%h resp=%b data=%h want 0", mem_valid, mem_addr, resp_valid, resp_data); end
    step(); rst_n = 1; step();
    mem_rvalid = 1; mem_rdata = 64'h1234_5678_9ABC_DEF0;
    step();
    mem_rvalid = 0;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_valid !== 1'b0) begin n_fail++;
        $display("FAIL rmid_stray[%0d]: got resp=%b ready=%b mem=%b want 0/1/0", i, resp_valid, req_ready, mem_valid); end
      step();
    end
  endtask

  initial begin
    req_valid = 0; req_wen = 0; req_func3 = 0; req_addr = 0; req_wdata = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; resp_ready = 0;
    test_reset();
    test_store_sw();
    test_load_lb();
    test_misaligned();
    test_stall();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
